// File: rtl/pps_monitor_if.sv
// PPS monitor bus: raw PPS level in, tick/period/lock/loss status out.
// master = the monitor that produces status, slave = whoever consumes it.
interface pps_monitor_if;
  logic        pps_in;
  logic        pps_tick;
  logic        period_valid;
  logic [31:0] last_period;
  logic        locked;
  logic        lost;
  logic [7:0]  lost_cnt;
  logic [31:0] sec_count;
  logic        led;

  modport master (
    input  pps_in,
    output pps_tick, period_valid, last_period, locked, lost, lost_cnt, sec_count, led
  );

  modport slave (
    output pps_in,
    input  pps_tick, period_valid, last_period, locked, lost, lost_cnt, sec_count, led
  );
endinterface

// File: rtl/pps_monitor.sv
// Synchronizes a PPS level, ticks on rising edges, measures edge spacing,
// qualifies lock against a nominal period and flags loss of signal.
module pps_monitor #(
  parameter int unsigned NOMINAL_CYCLES = 100000000,
  parameter int unsigned TOLERANCE      = 1000,
  parameter int unsigned TIMEOUT_CYCLES = 150000000,
  parameter int unsigned LOCK_COUNT     = 3
) (
  input  logic         iclk,
  input  logic         irst,
  pps_monitor_if.master bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_ACQ, ST_LOCKED, ST_LOST} state_t;

  localparam logic [32:0] P_LO    = 33'(NOMINAL_CYCLES) - 33'(TOLERANCE);
  localparam logic [32:0] P_HI    = 33'(NOMINAL_CYCLES) + 33'(TOLERANCE);
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [4:0]  LOCK5   = 5'(LOCK_COUNT);

  state_t      state_q, state_d;
  logic [3:0]  run_q, run_d;
  logic        s1_q, s1_d, s2_q, s2_d, prev_q, prev_d;
  logic [2:0]  vld_q, vld_d;
  logic [31:0] cnt_q, cnt_d;
  logic        pps_tick_q, pps_tick_d;
  logic        period_valid_q, period_valid_d;
  logic [31:0] last_period_q, last_period_d;
  logic [31:0] sec_count_q, sec_count_d;
  logic [7:0]  lost_cnt_q, lost_cnt_d;
  logic        led_q, led_d;

  logic        edge_w, good, tmo, lock_hit;
  logic [32:0] p_ext;
  logic [31:0] p_sat;

  // vld_q marks which synchronizer stages hold real samples since reset, so a
  // level held high through reset cannot masquerade as a rising edge.
  assign edge_w   = s2_q & ~prev_q & vld_q[2];
  assign p_ext    = {1'b0, cnt_q} + 33'd1;
  assign p_sat    = p_ext[32] ? '1 : p_ext[31:0];
  assign good     = ({1'b0, p_sat} >= P_LO) && ({1'b0, p_sat} <= P_HI);
  assign tmo      = (cnt_q == TO_LAST) && !edge_w;
  assign lock_hit = ({1'b0, run_q} + 5'd1) == LOCK5;

  always_comb begin
    s1_d   = bus.pps_in;
    s2_d   = s1_q;
    prev_d = s2_q;
    vld_d  = {vld_q[1:0], 1'b1};
    if (edge_w) begin
      cnt_d = '0;
    end else if (&cnt_q) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      state_q <= ST_IDLE;
      run_q   <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
    end
  end

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    case (state_q)
      ST_IDLE, ST_LOST: begin
        if (edge_w) begin
          state_d = ST_ACQ;
          run_d   = '0;
        end
      end
      ST_ACQ: begin
        if (edge_w) begin
          if (good) begin
            run_d = run_q + 4'd1;
            if (lock_hit) state_d = ST_LOCKED;
          end else begin
            run_d = '0;
          end
        end else if (tmo) begin
          state_d = ST_LOST;
        end
      end
      ST_LOCKED: begin
        if (edge_w) begin
          if (!good) begin
            state_d = ST_ACQ;
            run_d   = '0;
          end
        end else if (tmo) begin
          state_d = ST_LOST;
        end
      end
      default: begin
        state_d = ST_IDLE;
        run_d   = '0;
      end
    endcase
  end

  always_comb begin
    logic rec;
    rec            = edge_w && (state_q == ST_ACQ || state_q == ST_LOCKED);
    pps_tick_d     = edge_w;
    period_valid_d = rec;
    last_period_d  = rec ? p_sat : last_period_q;
    sec_count_d    = sec_count_q;
    if (edge_w && good && ((state_q == ST_ACQ && lock_hit) || state_q == ST_LOCKED)) begin
      sec_count_d = sec_count_q + 32'd1;
    end
    lost_cnt_d = lost_cnt_q;
    if (state_d == ST_LOST && state_q != ST_LOST && lost_cnt_q != 8'hFF) begin
      lost_cnt_d = lost_cnt_q + 8'd1;
    end
    case (state_d)
      ST_LOCKED: led_d = s2_q;
      ST_LOST:   led_d = 1'b1;
      default:   led_d = 1'b0;
    endcase
  end

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      s1_q           <= 1'b0;
      s2_q           <= 1'b0;
      prev_q         <= 1'b0;
      vld_q          <= '0;
      cnt_q          <= '0;
      pps_tick_q     <= 1'b0;
      period_valid_q <= 1'b0;
      last_period_q  <= '0;
      sec_count_q    <= '0;
      lost_cnt_q     <= '0;
      led_q          <= 1'b0;
    end else begin
      s1_q           <= s1_d;
      s2_q           <= s2_d;
      prev_q         <= prev_d;
      vld_q          <= vld_d;
      cnt_q          <= cnt_d;
      pps_tick_q     <= pps_tick_d;
      period_valid_q <= period_valid_d;
      last_period_q  <= last_period_d;
      sec_count_q    <= sec_count_d;
      lost_cnt_q     <= lost_cnt_d;
      led_q          <= led_d;
    end
  end

  assign bus.pps_tick     = pps_tick_q;
  assign bus.period_valid = period_valid_q;
  assign bus.last_period  = last_period_q;
  assign bus.locked       = (state_q == ST_LOCKED);
  assign bus.lost         = (state_q == ST_LOST);
  assign bus.lost_cnt     = lost_cnt_q;
  assign bus.sec_count    = sec_count_q;
  assign bus.led          = led_q;

endmodule
